immediate_pipeline: RTL and testbench
=====================================

IMMEDIATE_PIPELINE -- requirements
Module: immediate_pipeline

Interface
REQ-001 SHALL provide parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL provide parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-003 SHALL have port I_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port I_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port I_flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port I_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port O_ready  output  1  block can accept an instruction this cycle.
REQ-008 SHALL have port I_immsel  input  3  immediate format select (encodings in REQ-014).
REQ-009 SHALL have port I_data  input  32  raw instruction word.
REQ-010 SHALL have port I_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-011 SHALL have port O_valid  output  1  O_data/O_type/O_tag hold a valid entry.
REQ-012 SHALL have port I_ready  input  1  downstream accepts the entry this cycle.
REQ-013 SHALL have ports O_data (output, XLEN, immediate), O_type (output, 3, resolved format), O_tag (output, TAG_W, tag).

Function
REQ-014 SHALL decode I_immsel: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R (shift amount), 110 Z (CSR zimm), 111 AUTO.
REQ-015 SHALL, for AUTO, resolve from I_data[6:0]/[14:12]: 0010011 with funct3 001/101 -> R, other 0010011 -> I; 0000011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 1110011 with funct3[2]=1 -> Z, else I; any other opcode -> I.
REQ-016 SHALL form I/S/B/U/J immediates per RV32I bit placement, sign-extended from I_data[31] to XLEN bits; U has bits [11:0]=0; B and J have bit 0=0.
REQ-017 SHALL form R as I_data[24:20] zero-extended when XLEN=32 and I_data[25:20] zero-extended when XLEN=64.
REQ-018 SHALL form Z as I_data[19:15] zero-extended to XLEN.
REQ-019 SHALL drive O_type with the resolved format (never 111).
REQ-020 SHALL accept an instruction when I_valid && O_ready; a beat is delivered when O_valid && I_ready.
REQ-021 SHALL register the result: an accepted instruction appears on outputs no earlier than the next cycle; latency exactly 1 cycle when the output stage is empty or draining.
REQ-022 SHALL hold two entries, an output register and one skid register; O_ready SHALL be the registered inverse of skid-occupied (no combinational path from I_ready to O_ready).
REQ-023 SHALL route an accepted entry to the output register if it is empty or delivering this cycle, else to the skid register.
REQ-024 SHALL, when skid is occupied and the output delivers, move skid to output and clear skid in the same edge.
REQ-025 SHALL keep O_data/O_type/O_tag stable while O_valid && !I_ready.
REQ-026 SHALL preserve order; no entry lost or duplicated under any I_valid/I_ready pattern.
REQ-027 SHALL, on I_flush, clear both entries' valid bits at the edge; an input presented that cycle is dropped; the output beat that cycle counts as delivered if I_ready.
REQ-028 SHALL give I_rst priority over I_flush and all handshakes.

Reset
REQ-029 SHALL, after I_rst, set O_valid=0, skid empty, O_ready=1, O_data=0, O_type=000, O_tag=0.
REQ-030 SHALL discard in-flight entries on reset mid-operation; the first accept after reset delivers on the following cycle.

Verification
REQ-031 SHALL cover XLEN=32, AUTO, I_data=0xFFF00093 (addi x1,x0,-1) -> next cycle O_valid=1, O_data=0xFFFFFFFF, O_type=000.
REQ-032 SHALL cover AUTO, I_data=0x00000463 (beq +8) -> O_data=0x00000008, O_type=010; I_data=0xFFF00073|0x5000 (csrrwi zimm=0) with rs1 field=31 -> O_data=0x1F, O_type=110.
REQ-033 SHALL cover XLEN=64, AUTO, I_data=0x02109093 (slli x1,x1,33) -> O_data=0x21, O_type=101; same word at XLEN=32 -> O_data=0x01.
REQ-034 SHALL cover I_ready=0 with tags 1,2,3 back-to-back -> tag1 on output, tag2 in skid, O_ready=0 holding tag3; I_ready=1 -> tags delivered 1,2,3 on consecutive cycles.
REQ-035 SHALL cover I_flush with both entries full and I_valid=1 -> next cycle O_valid=0, O_ready=1, flushed-cycle input never delivered.
REQ-036 SHALL cover I_rst asserted with O_valid=1 and skid full -> next cycle all outputs per REQ-029.

Source files
------------

// File: rtl/immediate_pipeline.sv
// RISC-V immediate extraction stage with a two-entry output buffer.
// The immediate format is either selected explicitly or resolved from the
// opcode. Results are registered into an output register backed by one skid
// register. O_ready depends only on the skid register's valid bit, so there is
// no combinational path from I_ready back to O_ready.
module immediate_pipeline #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_flush,
   input  logic             I_valid,
   output logic             O_ready,
   input  logic [2:0]       I_immsel,
   input  logic [31:0]      I_data,
   input  logic [TAG_W-1:0] I_tag,
   output logic             O_valid,
   input  logic             I_ready,
   output logic [XLEN-1:0]  O_data,
   output logic [2:0]       O_type,
   output logic [TAG_W-1:0] O_tag
);

   typedef enum logic [2:0] {
      FMT_I    = 3'b000,
      FMT_S    = 3'b001,
      FMT_B    = 3'b010,
      FMT_U    = 3'b011,
      FMT_J    = 3'b100,
      FMT_R    = 3'b101,
      FMT_Z    = 3'b110,
      FMT_AUTO = 3'b111
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0]  data;
      fmt_e             fmt;
      logic [TAG_W-1:0] tag;
   } entry_t;

   fmt_e        fmt;
   logic [XLEN-1:0] imm;
   entry_t      new_entry;

   entry_t      out_q;
   logic        out_valid;
   entry_t      skid_q;
   logic        skid_valid;

   logic        accept;
   logic        deliver;

   // Resolve the immediate format; AUTO is replaced by the opcode-derived format.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves fmt unassigned (no latch).
      fmt = fmt_e'(I_immsel);
      if (fmt == FMT_AUTO) begin
         case (I_data[6:0])
            7'b0010011: fmt = (I_data[13:12] == 2'b01) ? FMT_R : FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111,
            7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            7'b1110011: fmt = I_data[14] ? FMT_Z : FMT_I;
            default:    fmt = FMT_I;
         endcase
      end
   end

   // Build the XLEN-wide immediate for the resolved format.
   always_comb begin
      imm = XLEN'($signed(I_data[31:20]));
      case (fmt)
         FMT_S: imm = XLEN'($signed({I_data[31:25], I_data[11:7]}));
         FMT_B: imm = XLEN'($signed({I_data[31], I_data[7], I_data[30:25],
                                     I_data[11:8], 1'b0}));
         FMT_U: imm = XLEN'($signed({I_data[31:12], 12'b0}));
         FMT_J: imm = XLEN'($signed({I_data[31], I_data[19:12], I_data[20],
                                     I_data[30:21], 1'b0}));
         FMT_R: imm = (XLEN == 64) ? XLEN'(I_data[25:20]) : XLEN'(I_data[24:20]);
         FMT_Z: imm = XLEN'(I_data[19:15]);
         default: imm = XLEN'($signed(I_data[31:20]));
      endcase
   end

   assign new_entry = '{data: imm, fmt: fmt, tag: I_tag};
   assign O_ready   = ~skid_valid;
   assign accept    = I_valid & ~skid_valid;
   assign deliver   = out_valid & I_ready;

   // Output register plus skid register; skid drains into output first to keep order.
   always_ff @(posedge I_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (I_rst) begin
         out_valid  <= 1'b0;
         out_q      <= '0;
         // NOTE: only the skid valid bit is reset; its payload is never observed while invalid.
         skid_valid <= 1'b0;
      end else if (I_flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || deliver) begin
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_q      <= new_entry;
            out_valid  <= 1'b1;
         end else begin
            out_valid  <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= new_entry;
         skid_valid <= 1'b1;
      end
   end

   assign O_valid = out_valid;
   assign O_data  = out_q.data;
   assign O_type  = out_q.fmt;
   assign O_tag   = out_q.tag;

endmodule

// File: tb/tb_immediate_pipeline.sv
// Bench for immediate_pipeline: one XLEN=32 and one XLEN=64 instance share the
// same inputs. Directed steps first, then random traffic against an
// occupancy/queue reference model.
module tb_immediate_pipeline;

   logic        clk = 1'b0;
   logic        rst, flush, valid, ready;
   logic [2:0]  immsel;
   logic [31:0] data;
   logic [4:0]  tag;

   logic        ready32, valid32, ready64, valid64;
   logic [31:0] data32;
   logic [63:0] data64;
   logic [2:0]  type32, type64;
   logic [4:0]  tag32, tag64;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  fmt;
      logic [4:0]  tag;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   immediate_pipeline #(.XLEN(32), .TAG_W(5)) dut32 (
      .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(valid), .O_ready(ready32),
      .I_immsel(immsel), .I_data(data), .I_tag(tag), .O_valid(valid32),
      .I_ready(ready), .O_data(data32), .O_type(type32), .O_tag(tag32)
   );

   immediate_pipeline #(.XLEN(64), .TAG_W(5)) dut64 (
      .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_valid(valid), .O_ready(ready64),
      .I_immsel(immsel), .I_data(data), .I_tag(tag), .O_valid(valid64),
      .I_ready(ready), .O_data(data64), .O_type(type64), .O_tag(tag64)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   // Sign-extend the low n bits of v to 64 bits.
   function automatic logic [63:0] sext(input logic [63:0] v, input int n);
      logic [63:0] mask;
      mask = ~64'd0 << n;
      return v[n-1] ? (v | mask) : (v & ~mask);
   endfunction

   // Format implied by the select and instruction word.
   function automatic logic [2:0] resolve(input logic [2:0] sel, input logic [31:0] d);
      int op, f3;
      if (sel != 3'd7) return sel;
      op = int'(d[6:0]);
      f3 = int'(d[14:12]);
      if (op == 'h13) return (f3 == 1 || f3 == 5) ? 3'd5 : 3'd0;
      if (op == 'h23) return 3'd1;
      if (op == 'h63) return 3'd2;
      if (op == 'h37 || op == 'h17) return 3'd3;
      if (op == 'h6f) return 3'd4;
      if (op == 'h73) return (f3 >= 4) ? 3'd6 : 3'd0;
      return 3'd0;
   endfunction

   // Immediate value computed arithmetically from field positions.
   function automatic logic [63:0] imm_of(input logic [31:0] d, input logic [2:0] fmt, input bit x64);
      logic [63:0] w, r;
      w = {32'd0, d};
      case (fmt)
         3'd1: r = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
         3'd2: r = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                        (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
         3'd3: r = sext(w & 64'hFFFF_F000, 32);
         3'd4: r = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                        (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
         3'd5: r = x64 ? ((w >> 20) & 63) : ((w >> 20) & 31);
         3'd6: r = (w >> 15) & 31;
         default: r = sext(w >> 20, 12);
      endcase
      return x64 ? r : (r & 64'hFFFF_FFFF);
   endfunction

   task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d,
                        input logic [4:0] t, input logic r);
      valid = v; immsel = s; data = d; tag = t; ready = r;
   endtask

   task automatic check_reset_state(input string name);
      check({name, ".valid32"}, {63'd0, valid32}, 64'd0);
      check({name, ".ready32"}, {63'd0, ready32}, 64'd1);
      check({name, ".data32"},  {32'd0, data32}, 64'd0);
      check({name, ".type32"},  {61'd0, type32}, 64'd0);
      check({name, ".tag32"},   {59'd0, tag32}, 64'd0);
      check({name, ".valid64"}, {63'd0, valid64}, 64'd0);
      check({name, ".data64"},  data64, 64'd0);
      check({name, ".ready64"}, {63'd0, ready64}, 64'd1);
   endtask

   initial begin
      logic [6:0] ops [10];
      logic       do_flush;
      exp_t       e;

      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33};

      // Reset state.
      rst = 1'b1; flush = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // addi x1,x0,-1 via AUTO.
      drive(1'b1, 3'd7, 32'hFFF0_0093, 5'd1, 1'b1);
      @(negedge clk);
      check("addi.valid", {63'd0, valid32}, 64'd1);
      check("addi.data32", {32'd0, data32}, 64'hFFFF_FFFF);
      check("addi.data64", data64, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi.type", {61'd0, type32}, 64'd0);
      check("addi.tag", {59'd0, tag32}, 64'd1);

      // beq +8.
      drive(1'b1, 3'd7, 32'h0000_0463, 5'd2, 1'b1);
      @(negedge clk);
      check("beq.data32", {32'd0, data32}, 64'h8);
      check("beq.type", {61'd0, type32}, 64'd2);

      // csrrwi with rs1 field = 31.
      drive(1'b1, 3'd7, 32'hFFF0_5073 | (32'd31 << 15), 5'd3, 1'b1);
      @(negedge clk);
      check("csr.data32", {32'd0, data32}, 64'h1F);
      check("csr.type", {61'd0, type32}, 64'd6);

      // slli x1,x1,33: shift amount width depends on XLEN.
      drive(1'b1, 3'd7, 32'h0210_9093, 5'd4, 1'b1);
      @(negedge clk);
      check("slli.data64", data64, 64'h21);
      check("slli.type64", {61'd0, type64}, 64'd5);
      check("slli.data32", {32'd0, data32}, 64'h1);

      drive(1'b0, 3'd0, 32'd0, 5'd0, 1'b1);
      @(negedge clk);
      check("drain.valid", {63'd0, valid32}, 64'd0);

      // Backpressure: tags 1,2,3 with I_ready=0.
      drive(1'b1, 3'd0, 32'h0010_0013, 5'd1, 1'b0);
      @(negedge clk);
      check("bp1.tag", {59'd0, tag32}, 64'd1);
      check("bp1.ready", {63'd0, ready32}, 64'd1);
      drive(1'b1, 3'd0, 32'h0020_0013, 5'd2, 1'b0);
      @(negedge clk);
      check("bp2.tag", {59'd0, tag32}, 64'd1);
      check("bp2.ready", {63'd0, ready32}, 64'd0);
      drive(1'b1, 3'd0, 32'h0030_0013, 5'd3, 1'b0);
      @(negedge clk);
      check("bp3.tag_held", {59'd0, tag32}, 64'd1);
      check("bp3.data_held", {32'd0, data32}, 64'h1);
      check("bp3.ready", {63'd0, ready32}, 64'd0);
      ready = 1'b1;
      @(negedge clk);
      check("bp4.tag", {59'd0, tag32}, 64'd2);
      check("bp4.ready", {63'd0, ready32}, 64'd1);
      @(negedge clk);
      check("bp5.tag", {59'd0, tag32}, 64'd3);
      check("bp5.data", {32'd0, data32}, 64'h3);
      valid = 1'b0;
      @(negedge clk);
      check("bp6.valid", {63'd0, valid32}, 64'd0);

      // Flush with both entries full and an input presented.
      drive(1'b1, 3'd0, 32'd0, 5'd4, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd0, 32'd0, 5'd5, 1'b0);
      @(negedge clk);
      check("fl.full", {63'd0, ready32}, 64'd0);
      flush = 1'b1;
      drive(1'b1, 3'd0, 32'd0, 5'd6, 1'b0);
      @(negedge clk);
      check("fl.valid", {63'd0, valid32}, 64'd0);
      check("fl.ready", {63'd0, ready32}, 64'd1);
      flush = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 5'd0, 1'b1);
      @(negedge clk);
      check("fl.dropped", {63'd0, valid32}, 64'd0);

      // Reset with both entries full.
      drive(1'b1, 3'd3, 32'hABCD_E037, 5'd7, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd3, 32'h1234_5037, 5'd8, 1'b0);
      @(negedge clk);
      check("rs.full_valid", {63'd0, valid32}, 64'd1);
      check("rs.full_ready", {63'd0, ready32}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("midreset");
      rst = 1'b0;
      drive(1'b1, 3'd1, 32'hFE00_0FA3, 5'd9, 1'b1);
      @(negedge clk);
      check("rs.first_valid", {63'd0, valid32}, 64'd1);
      check("rs.first_tag", {59'd0, tag32}, 64'd9);
      check("rs.first_data", {32'd0, data32}, 64'hFFFF_FFFF);
      drive(1'b0, 3'd0, 32'd0, 5'd0, 1'b1);
      @(negedge clk);
      check("rs.empty", {63'd0, valid32}, 64'd0);

      // Random traffic against the queue model (pipeline is empty here).
      for (int cyc = 0; cyc < 2000; cyc++) begin
         check("rnd.valid32", {63'd0, valid32}, {63'd0, q.size() != 0});
         check("rnd.ready32", {63'd0, ready32}, {63'd0, q.size() < 2});
         check("rnd.valid64", {63'd0, valid64}, {63'd0, q.size() != 0});
         check("rnd.ready64", {63'd0, ready64}, {63'd0, q.size() < 2});
         if (q.size() != 0) begin
            check("rnd.data32", {32'd0, data32}, imm_of(q[0].d, q[0].fmt, 1'b0));
            check("rnd.data64", data64, imm_of(q[0].d, q[0].fmt, 1'b1));
            check("rnd.type32", {61'd0, type32}, {61'd0, q[0].fmt});
            check("rnd.type64", {61'd0, type64}, {61'd0, q[0].fmt});
            check("rnd.tag32", {59'd0, tag32}, {59'd0, q[0].tag});
            check("rnd.tag64", {59'd0, tag64}, {59'd0, q[0].tag});
         end
         valid  = ($urandom_range(0, 9) < 6);
         ready  = ($urandom_range(0, 9) < 6);
         do_flush = ($urandom_range(0, 99) < 3);
         flush  = do_flush;
         immsel = 3'($urandom_range(0, 7));
         data   = $urandom;
         if ($urandom_range(0, 1) == 1) data[6:0] = ops[$urandom_range(0, 9)];
         tag    = 5'($urandom_range(0, 31));
         // Apply the upcoming edge to the model.
         if (do_flush) begin
            q.delete();
         end else begin
            e.d = data; e.fmt = resolve(immsel, data); e.tag = tag;
            if (valid && q.size() < 2) begin
               if (q.size() != 0 && ready) void'(q.pop_front());
               q.push_back(e);
            end else if (q.size() != 0 && ready) begin
               void'(q.pop_front());
            end
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
